// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback queue: default widths, the queued
// entry layout and a register one-hot helper.
package wb_pkg;

  localparam int unsigned WORD_WIDTH = 16;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WORD_WIDTH-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
    reg_onehot     = '0;
    reg_onehot[rd] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO with two same-edge write ports (push0 lands before push1) and a
// single pop; every slot and its valid bit are exposed for hazard/forward logic.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push0,
  input  entry_t                    push0_entry,
  input  logic                      push1,
  input  entry_t                    push1_entry,
  input  logic                      pop,
  output logic [$clog2(DEPTH):0]    count,
  output logic [$clog2(DEPTH)-1:0]  head_ptr,
  output entry_t                    entries [DEPTH],
  output logic [DEPTH-1:0]          valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   wr_ptr_next1;
  logic [CNT_W-1:0]   n_push;

  assign wr_ptr_next1 = wr_ptr + PTR_W'(1);
  assign n_push       = CNT_W'(push0) + CNT_W'(push1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + n_push - CNT_W'(pop);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push0) begin
        mem[wr_ptr] <= push0_entry;
      end
      if (push1) begin
        mem[wr_ptr_next1] <= push1_entry;
      end
    end
  end

  assign head_ptr = rd_ptr;
  assign entries  = mem;

  always_comb begin
    logic [PTR_W-1:0] off;
    off   = '0;
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off      = PTR_W'(i) - rd_ptr;
      valid[i] = CNT_W'(off) < count;
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Writeback stage: ALU/load handshakes, r0 filtering, in-order retire and the
// per-register pending mask. Define WB_FORWARD_EN to add the forwarding ports.
module writeback_queue #(
  parameter int unsigned WORD_WIDTH = wb_pkg::WORD_WIDTH,
  parameter int unsigned REG_ADDR_W = wb_pkg::REG_ADDR_W,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [REG_ADDR_W-1:0]      alu_rd,
  input  logic [WORD_WIDTH-1:0]      alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [REG_ADDR_W-1:0]      mem_rd,
  input  logic [WORD_WIDTH-1:0]      mem_data,
  output logic                       write_en,
  output logic [REG_ADDR_W-1:0]      wb_rd,
  output logic [WORD_WIDTH-1:0]      wb_data,
  output logic [2**REG_ADDR_W-1:0]   pending,
`ifdef WB_FORWARD_EN
  input  logic [REG_ADDR_W-1:0]      fwd_rs,
  input  logic [REG_ADDR_W-1:0]      fwd_rt,
  output logic                       fwd_rs_hit,
  output logic                       fwd_rt_hit,
  output logic [WORD_WIDTH-1:0]      fwd_rs_val,
  output logic [WORD_WIDTH-1:0]      fwd_rt_val,
`endif
  output logic                       empty
);

  import wb_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WORD_WIDTH-1:0] data;
  } entry_t;

  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  head_ptr;
  entry_t            entries [DEPTH];
  logic [DEPTH-1:0]  valid;
  entry_t            head;

  logic              mem_push;
  logic              alu_push;
  logic              push0;
  logic              push1;
  entry_t            push0_entry;
  entry_t            push1_entry;
  logic              pop;

  // Readiness looks only at the current count; the same-edge pop earns no credit.
  always_comb begin
    mem_ready = !rst && (count <= CNT_W'(DEPTH - 1));
    alu_ready = !rst && (count <= (mem_valid ? CNT_W'(DEPTH - 2) : CNT_W'(DEPTH - 1)));
  end

  assign mem_push = mem_valid && mem_ready && (mem_rd != '0);
  assign alu_push = alu_valid && alu_ready && (alu_rd != '0);

  // Pushes are packed onto port 0 first so a lone ALU result never leaves a gap.
  always_comb begin
    push0       = mem_push || alu_push;
    push1       = mem_push && alu_push;
    push0_entry = mem_push ? entry_t'{rd: mem_rd, data: mem_data}
                           : entry_t'{rd: alu_rd, data: alu_data};
    push1_entry = entry_t'{rd: alu_rd, data: alu_data};
  end

  assign pop = (count != '0);

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push0       (push0),
    .push0_entry (push0_entry),
    .push1       (push1),
    .push1_entry (push1_entry),
    .pop         (pop),
    .count       (count),
    .head_ptr    (head_ptr),
    .entries     (entries),
    .valid       (valid)
  );

  // Gating with rst keeps queued writes off the register file in the reset cycle.
  assign empty    = rst || (count == '0);
  assign write_en = !empty;
  assign head     = entries[head_ptr];
  assign wb_rd    = write_en ? head.rd   : '0;
  assign wb_data  = write_en ? head.data : '0;

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i]) begin
        pending[entries[i].rd] = 1'b1;
      end
    end
    pending[0] = 1'b0;
    if (rst) begin
      pending = '0;
    end
  end

`ifdef WB_FORWARD_EN
  // Walk oldest to youngest so the last match seen is the youngest writer.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    fwd_rs_hit = 1'b0;
    fwd_rt_hit = 1'b0;
    fwd_rs_val = '0;
    fwd_rt_val = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_ptr + PTR_W'(k);
      if (!rst && (CNT_W'(k) < count)) begin
        if ((fwd_rs != '0) && (entries[idx].rd == fwd_rs)) begin
          fwd_rs_hit = 1'b1;
          fwd_rs_val = entries[idx].data;
        end
        if ((fwd_rt != '0) && (entries[idx].rd == fwd_rt)) begin
          fwd_rt_hit = 1'b1;
          fwd_rt_val = entries[idx].data;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: stimulus pushes expected register writes,
// a negedge monitor pops and compares them along with pending/empty/forwarding.
module tb_writeback_queue;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 16;
  localparam int unsigned A     = 3;
  localparam int unsigned N     = 8;

  typedef struct packed {
    logic [A-1:0] rd;
    logic [W-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, alu_ready, mem_valid, mem_ready;
  logic [A-1:0]  alu_rd, mem_rd, wb_rd;
  logic [W-1:0]  alu_data, mem_data, wb_data;
  logic          write_en, empty;
  logic [N-1:0]  pending;
`ifdef WB_FORWARD_EN
  logic [A-1:0]  fwd_rs, fwd_rt;
  logic          fwd_rs_hit, fwd_rt_hit;
  logic [W-1:0]  fwd_rs_val, fwd_rt_val;
`endif

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   fwd_random = 1'b1;

  always #5 clk = ~clk;

  writeback_queue #(
    .WORD_WIDTH (W),
    .REG_ADDR_W (A),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .write_en   (write_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .pending    (pending),
`ifdef WB_FORWARD_EN
    .fwd_rs     (fwd_rs),
    .fwd_rt     (fwd_rt),
    .fwd_rs_hit (fwd_rs_hit),
    .fwd_rt_hit (fwd_rt_hit),
    .fwd_rs_val (fwd_rs_val),
    .fwd_rt_val (fwd_rt_val),
`endif
    .empty      (empty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the set of queued writes is exactly the outstanding scoreboard.
  function automatic logic [N-1:0] model_pending();
    logic [N-1:0] m = '0;
    foreach (sb[i]) m |= reg_onehot(sb[i].rd);
    return m;
  endfunction

  // Monitor: one sample per cycle, away from the rising edge.
  initial begin
    exp_t e;
`ifdef WB_FORWARD_EN
    logic         h_rs, h_rt;
    logic [W-1:0] v_rs, v_rt;
`endif
    forever begin
      @(negedge clk);
      if (rst) begin
        check("write_en_in_reset", write_en, 0);
      end else begin
        check("pending", pending, model_pending());
        check("empty", empty, sb.size() == 0);
        check("write_en", write_en, sb.size() != 0);
        if (sb.size() == 0) begin
          check("wb_rd_idle", wb_rd, 0);
          check("wb_data_idle", wb_data, 0);
        end else if (write_en) begin
          e = sb.pop_front();
          check("wb_rd", wb_rd, e.rd);
          check("wb_data", wb_data, e.data);
        end
`ifdef WB_FORWARD_EN
        h_rs = 1'b0; h_rt = 1'b0; v_rs = '0; v_rt = '0;
        if (write_en && sb.size() >= 0) begin
          // head already popped from sb above; include it as the oldest entry
          if (e.rd == fwd_rs && fwd_rs != 0) begin h_rs = 1'b1; v_rs = e.data; end
          if (e.rd == fwd_rt && fwd_rt != 0) begin h_rt = 1'b1; v_rt = e.data; end
        end
        foreach (sb[i]) begin
          if (sb[i].rd == fwd_rs && fwd_rs != 0) begin h_rs = 1'b1; v_rs = sb[i].data; end
          if (sb[i].rd == fwd_rt && fwd_rt != 0) begin h_rt = 1'b1; v_rt = sb[i].data; end
        end
        check("fwd_rs_hit", fwd_rs_hit, h_rs);
        check("fwd_rt_hit", fwd_rt_hit, h_rt);
        if (h_rs) check("fwd_rs_val", fwd_rs_val, v_rs);
        if (h_rt) check("fwd_rt_val", fwd_rt_val, v_rt);
`endif
      end
    end
  end

  // One cycle of offers; returns what the reference model says was accepted.
  task automatic drive(input bit mv, input logic [A-1:0] mrd, input logic [W-1:0] md,
                       input bit av, input logic [A-1:0] ard, input logic [W-1:0] ad,
                       output bit m_acc, output bit a_acc);
    bit exp_mr, exp_ar;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
`ifdef WB_FORWARD_EN
    if (fwd_random) begin
      fwd_rs = A'($urandom);
      fwd_rt = A'($urandom);
    end
`endif
    #1;
    exp_mr = !rst && (sb.size() <= int'(DEPTH) - 1);
    exp_ar = !rst && (sb.size() <= (mv ? int'(DEPTH) - 2 : int'(DEPTH) - 1));
    check("mem_ready", mem_ready, exp_mr);
    check("alu_ready", alu_ready, exp_ar);
    m_acc = mv && exp_mr;
    a_acc = av && exp_ar;
    @(posedge clk);
    if (rst) begin
      sb.delete();
    end else begin
      if (m_acc && mrd != 0) sb.push_back('{rd: mrd, data: md});
      if (a_acc && ard != 0) sb.push_back('{rd: ard, data: ad});
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit ma, aa;
    for (int i = 0; i < n; i++) drive(0, '0, '0, 0, '0, '0, ma, aa);
  endtask

  initial begin
    bit ma, aa;
    bit mv, av;
    logic [A-1:0] mrd, ard;
    logic [W-1:0] md, ad;
    int mi, ai, guard;

    rst = 1'b1;
    mem_valid = 0; alu_valid = 0;
    mem_rd = '0; alu_rd = '0; mem_data = '0; alu_data = '0;
`ifdef WB_FORWARD_EN
    fwd_rs = '0; fwd_rt = '0;
`endif
    idle(2);
    rst = 1'b0;
    idle(2);

    // Single ALU write, then a simultaneous load+ALU pair.
    drive(0, '0, '0, 1, 3'd3, 16'h1234, ma, aa);
    idle(3);
    drive(1, 3'd2, 16'hAAAA, 1, 3'd5, 16'h5555, ma, aa);
    idle(3);

    // Fill: 4 loads and 4 ALU results back to back with held offers.
    mi = 0; ai = 0; guard = 0;
    mv = 0; av = 0; mrd = '0; ard = '0; md = '0; ad = '0;
    while ((mi < 4 || ai < 4 || mv || av) && guard < 20) begin
      if (!mv && mi < 4) begin mv = 1; mrd = A'($urandom_range(1, 7)); md = W'($urandom); mi++; end
      if (!av && ai < 4) begin av = 1; ard = A'($urandom_range(1, 7)); ad = W'($urandom); ai++; end
      drive(mv, mrd, md, av, ard, ad, ma, aa);
      if (ma) mv = 0;
      if (aa) av = 0;
      guard++;
    end
    check("fill_completed", guard < 20, 1);
    idle(5);

    // Register 0 result: handshake only.
    drive(0, '0, '0, 1, 3'd0, 16'hFFFF, ma, aa);
    check("r0_accepted", aa, 1);
    idle(2);

    // Randomised traffic including rd=0.
    mv = 0; av = 0;
    for (int i = 0; i < 300; i++) begin
      if (!mv && $urandom_range(0, 2) != 0) begin mv = 1; mrd = A'($urandom); md = W'($urandom); end
      if (!av && $urandom_range(0, 2) != 0) begin av = 1; ard = A'($urandom); ad = W'($urandom); end
      drive(mv, mrd, md, av, ard, ad, ma, aa);
      if (ma) mv = 0;
      if (aa) av = 0;
    end
    idle(6);

    // Three entries queued (two to r4), then reset mid-operation.
    fwd_random = 1'b0;
`ifdef WB_FORWARD_EN
    fwd_rs = 3'd4; fwd_rt = 3'd6;
`endif
    drive(1, 3'd1, 16'h0101, 1, 3'd6, 16'h0606, ma, aa);
    drive(1, 3'd4, 16'h0001, 1, 3'd4, 16'h0002, ma, aa);
    check("pre_reset_queued", sb.size(), 3);
    @(negedge clk);
`ifdef WB_FORWARD_EN
    check("fwd_r4_hit_direct", fwd_rs_hit, 1);
    check("fwd_r4_val_direct", fwd_rs_val, 16'h0002);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("post_reset_empty", empty, 1);
    check("post_reset_pending", pending, 0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
